// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the handshake and bus signals of the unified memory port arbiter.
//   The instruction fetch, load/store and memory sides all live here. The clock
//   and reset stay as plain ports on the arbiter.
//   Modports:
//     slave  - the arbiter itself: takes the i_* signals, drives the o_* signals
//     master - the environment (requesters + memory): drives i_*, observes o_*
//   Signal groups:
//     fetch  : i_if_req, i_if_addr, o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err
//     ls     : i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
//              o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err
//     memory : o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
//              i_mem_ack, i_mem_rvalid, i_mem_rdata, i_mem_err
//     status : o_busy
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);

  // instruction fetch side
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_gnt;
  logic            o_if_rvalid;
  logic [XLEN-1:0] o_if_rdata;
  logic            o_if_err;

  // load/store side
  logic            i_ls_req;
  logic            i_ls_we;
  logic [3:0]      i_ls_be;
  logic [XLEN-1:0] i_ls_addr;
  logic [XLEN-1:0] i_ls_wdata;
  logic            o_ls_gnt;
  logic            o_ls_rvalid;
  logic [XLEN-1:0] o_ls_rdata;
  logic            o_ls_err;

  // unified memory port
  logic            o_mem_req;
  logic            o_mem_we;
  logic [3:0]      o_mem_be;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic            i_mem_ack;
  logic            i_mem_rvalid;
  logic [XLEN-1:0] i_mem_rdata;
  logic            i_mem_err;

  // status
  logic            o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    input  i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rvalid, i_mem_rdata, i_mem_err,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_if_err,
    output i_ls_req, i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rvalid, i_mem_rdata, i_mem_err,
    input  o_busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (read-only) and the
//   load/store unit (read/write). Only one transaction can be outstanding at a
//   time. LS has fixed priority, but after STARVE_MAX consecutive LS wins over a
//   pending fetch, the fetch is forced through. Every transaction has a response
//   timeout. When it expires, the owning requester gets an error response with
//   zero data.
//   Ports:
//     i_clk   - system clock
//     i_rst_n - asynchronous active-low reset; abandons any in-flight access
//     bus     - mem_port_arbiter_if.slave: fetch, LS, memory and status signals
//   Every output is registered. The next value of every output register is
//   computed in one combinational process, together with the next FSM state.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int   SW     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int   TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // state and bookkeeping
  state_e          state_r,     state_s;
  logic            owner_r,     owner_s;
  logic [SW-1:0]   starve_r,    starve_s;
  logic [TW-1:0]   tmo_r,       tmo_s;

  // registered outputs
  logic            mem_req_r,   mem_req_s;
  logic            mem_we_r,    mem_we_s;
  logic [3:0]      mem_be_r,    mem_be_s;
  logic [XLEN-1:0] mem_addr_r,  mem_addr_s;
  logic [XLEN-1:0] mem_wdata_r, mem_wdata_s;
  logic            if_gnt_r,    if_gnt_s;
  logic            ls_gnt_r,    ls_gnt_s;
  logic            if_rvalid_r, if_rvalid_s;
  logic            ls_rvalid_r, ls_rvalid_s;
  logic [XLEN-1:0] if_rdata_r,  if_rdata_s;
  logic [XLEN-1:0] ls_rdata_r,  ls_rdata_s;
  logic            if_err_r,    if_err_s;
  logic            ls_err_r,    ls_err_s;
  logic            busy_r,      busy_s;

  // arbitration decision, only meaningful in IDLE
  logic            any_req_s;
  logic            ls_wins_s;
  logic            starved_s;

  assign any_req_s = bus.i_if_req | bus.i_ls_req;
  assign starved_s = bus.i_if_req & (starve_r == SW'(STARVE_MAX));
  assign ls_wins_s = bus.i_ls_req & ~starved_s;

  // Next-state and next-output computation for the arbiter FSM
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    starve_s    = starve_r;
    tmo_s       = tmo_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_be_s    = mem_be_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    if_gnt_s    = 1'b0;
    ls_gnt_s    = 1'b0;
    if_rvalid_s = 1'b0;
    ls_rvalid_s = 1'b0;
    if_rdata_s  = if_rdata_r;
    ls_rdata_s  = ls_rdata_r;
    if_err_s    = if_err_r;
    ls_err_s    = ls_err_r;

    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s   = ST_REQ;
          mem_req_s = 1'b1;
          if (ls_wins_s) begin
            owner_s     = OWN_LS;
            ls_gnt_s    = 1'b1;
            mem_we_s    = bus.i_ls_we;
            mem_be_s    = bus.i_ls_be;
            mem_addr_s  = bus.i_ls_addr;
            mem_wdata_s = bus.i_ls_wdata;
            // Only wins taken against a waiting fetch count toward starvation.
            // The counter cannot pass STARVE_MAX, because at that value the
            // fetch wins instead.
            if (bus.i_if_req) begin
              starve_s = starve_r + SW'(1);
            end else begin
              starve_s = starve_r;
            end
          end else begin
            owner_s     = OWN_IF;
            if_gnt_s    = 1'b1;
            mem_we_s    = 1'b0;
            mem_be_s    = 4'hF;
            mem_addr_s  = bus.i_if_addr;
            mem_wdata_s = {XLEN{1'b0}};
            starve_s    = {SW{1'b0}};
          end
        end else begin
          state_s   = ST_IDLE;
          mem_req_s = 1'b0;
        end
      end

      ST_REQ: begin
        if (bus.i_mem_ack) begin
          state_s   = ST_WAIT;
          mem_req_s = 1'b0;
          tmo_s     = {TW{1'b0}};
        end else begin
          state_s   = ST_REQ;
          mem_req_s = 1'b1;
        end
      end

      ST_WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_s = ST_RESP;
          if (owner_r == OWN_LS) begin
            ls_rvalid_s = 1'b1;
            ls_rdata_s  = bus.i_mem_rdata;
            ls_err_s    = bus.i_mem_err;
          end else begin
            if_rvalid_s = 1'b1;
            if_rdata_s  = bus.i_mem_rdata;
            if_err_s    = bus.i_mem_err;
          end
        end else if (tmo_r == TW'(TIMEOUT - 1)) begin
          // The memory never answered. Return an error with zero data.
          state_s = ST_RESP;
          if (owner_r == OWN_LS) begin
            ls_rvalid_s = 1'b1;
            ls_rdata_s  = {XLEN{1'b0}};
            ls_err_s    = 1'b1;
          end else begin
            if_rvalid_s = 1'b1;
            if_rdata_s  = {XLEN{1'b0}};
            if_err_s    = 1'b1;
          end
        end else begin
          state_s = ST_WAIT;
          tmo_s   = tmo_r + TW'(1);
        end
      end

      ST_RESP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, bookkeeping and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_IF;
      starve_r    <= {SW{1'b0}};
      tmo_r       <= {TW{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'h0;
      mem_addr_r  <= {XLEN{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
      if_gnt_r    <= 1'b0;
      ls_gnt_r    <= 1'b0;
      if_rvalid_r <= 1'b0;
      ls_rvalid_r <= 1'b0;
      if_rdata_r  <= {XLEN{1'b0}};
      ls_rdata_r  <= {XLEN{1'b0}};
      if_err_r    <= 1'b0;
      ls_err_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      starve_r    <= starve_s;
      tmo_r       <= tmo_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_be_r    <= mem_be_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if_gnt_r    <= if_gnt_s;
      ls_gnt_r    <= ls_gnt_s;
      if_rvalid_r <= if_rvalid_s;
      ls_rvalid_r <= ls_rvalid_s;
      if_rdata_r  <= if_rdata_s;
      ls_rdata_r  <= ls_rdata_s;
      if_err_r    <= if_err_s;
      ls_err_r    <= ls_err_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.o_mem_req   = mem_req_r;
  assign bus.o_mem_we    = mem_we_r;
  assign bus.o_mem_be    = mem_be_r;
  assign bus.o_mem_addr  = mem_addr_r;
  assign bus.o_mem_wdata = mem_wdata_r;
  assign bus.o_if_gnt    = if_gnt_r;
  assign bus.o_ls_gnt    = ls_gnt_r;
  assign bus.o_if_rvalid = if_rvalid_r;
  assign bus.o_ls_rvalid = ls_rvalid_r;
  assign bus.o_if_rdata  = if_rdata_r;
  assign bus.o_ls_rdata  = ls_rdata_r;
  assign bus.o_if_err    = if_err_r;
  assign bus.o_ls_err    = ls_err_r;
  assign bus.o_busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8).
//   Stimulus pushes the expected grants and responses into queues. A monitor
//   running on the falling clock edge pops an entry whenever the DUT shows a
//   grant or response pulse, and compares it with the DUT outputs.
module tb_mem_port_arbiter;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_port_arbiter #(
    .XLEN       (XLEN),
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        ls;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        ls;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  gnt_t mon_g;
  rsp_t mon_r;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic gnt_t mk_gnt(input logic ls, input logic we, input logic [3:0] be,
                                  input logic [31:0] addr, input logic [31:0] wdata);
    gnt_t g;
    g.ls = ls; g.we = we; g.be = be; g.addr = addr; g.wdata = wdata;
    return g;
  endfunction

  function automatic rsp_t mk_rsp(input logic ls, input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.ls = ls; r.rdata = rdata; r.err = err;
    return r;
  endfunction

  // Monitor: compares every grant / response pulse against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_if_gnt || bus.o_ls_gnt) begin
        check("gnt_exclusive", {31'd0, bus.o_if_gnt & bus.o_ls_gnt}, 32'd0);
        check("gnt_expected", {31'd0, gnt_q.size() != 0}, 32'd1);
        if (gnt_q.size() != 0) begin
          mon_g = gnt_q.pop_front();
          check("gnt_owner", {31'd0, bus.o_ls_gnt}, {31'd0, mon_g.ls});
          check("gnt_mem_req", {31'd0, bus.o_mem_req}, 32'd1);
          check("gnt_mem_we", {31'd0, bus.o_mem_we}, {31'd0, mon_g.we});
          check("gnt_mem_be", {28'd0, bus.o_mem_be}, {28'd0, mon_g.be});
          check("gnt_mem_addr", bus.o_mem_addr, mon_g.addr);
          check("gnt_mem_wdata", bus.o_mem_wdata, mon_g.wdata);
        end
      end
      if (bus.o_if_rvalid || bus.o_ls_rvalid) begin
        check("rsp_exclusive", {31'd0, bus.o_if_rvalid & bus.o_ls_rvalid}, 32'd0);
        check("rsp_expected", {31'd0, rsp_q.size() != 0}, 32'd1);
        if (rsp_q.size() != 0) begin
          mon_r = rsp_q.pop_front();
          check("rsp_owner", {31'd0, bus.o_ls_rvalid}, {31'd0, mon_r.ls});
          if (mon_r.ls) begin
            check("rsp_ls_rdata", bus.o_ls_rdata, mon_r.rdata);
            check("rsp_ls_err", {31'd0, bus.o_ls_err}, {31'd0, mon_r.err});
          end else begin
            check("rsp_if_rdata", bus.o_if_rdata, mon_r.rdata);
            check("rsp_if_err", {31'd0, bus.o_if_err}, {31'd0, mon_r.err});
          end
        end
      end
    end
  end

  // One transaction: wait for o_mem_req, drop the granted request, ack, respond
  // (or let it time out), then return at the first IDLE cycle.
  task automatic txn(input int ack_dly, input int rsp_dly, input logic do_rsp,
                     input logic [31:0] rd, input logic er, input logic keep_ls);
    int n;
    n = 0;
    while (!bus.o_mem_req && n < 40) begin
      tick();
      n++;
    end
    check("mem_req_seen", {31'd0, bus.o_mem_req}, 32'd1);
    if (!bus.o_mem_req) return;
    if (bus.o_if_gnt) bus.i_if_req = 1'b0;
    else if (!keep_ls) bus.i_ls_req = 1'b0;
    repeat (ack_dly) tick();
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
    if (do_rsp) begin
      repeat (rsp_dly) tick();
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = rd;
      bus.i_mem_err    = er;
      tick();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = 32'd0;
      bus.i_mem_err    = 1'b0;
    end else begin
      repeat (TIMEOUT) tick();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_if_req     = 1'b0;
    bus.i_if_addr    = 32'd0;
    bus.i_ls_req     = 1'b0;
    bus.i_ls_we      = 1'b0;
    bus.i_ls_be      = 4'h0;
    bus.i_ls_addr    = 32'd0;
    bus.i_ls_wdata   = 32'd0;
    bus.i_mem_ack    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'd0;
    bus.i_mem_err    = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_mem_req", {31'd0, bus.o_mem_req}, 32'd0);
    check("rst_mem_be", {28'd0, bus.o_mem_be}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, bus.o_busy}, 32'd0);

    // single fetch with cycle-exact latency checks
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0100;
    gnt_q.push_back(mk_gnt(1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'd0));
    rsp_q.push_back(mk_rsp(1'b0, 32'h0000_0013, 1'b0));
    tick();                                    // c1
    check("f_c1_if_gnt", {31'd0, bus.o_if_gnt}, 32'd1);
    check("f_c1_busy", {31'd0, bus.o_busy}, 32'd1);
    bus.i_if_req  = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();                                    // c2
    bus.i_mem_ack = 1'b0;
    check("f_c2_mem_req", {31'd0, bus.o_mem_req}, 32'd0);
    check("f_c2_if_gnt", {31'd0, bus.o_if_gnt}, 32'd0);
    tick();                                    // c3
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h0000_0013;
    tick();                                    // c4
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'd0;
    check("f_c4_if_rvalid", {31'd0, bus.o_if_rvalid}, 32'd1);
    check("f_c4_busy", {31'd0, bus.o_busy}, 32'd1);
    tick();                                    // c5
    check("f_c5_if_rvalid", {31'd0, bus.o_if_rvalid}, 32'd0);
    check("f_c5_busy", {31'd0, bus.o_busy}, 32'd0);
    check("f_c5_rdata_hold", bus.o_if_rdata, 32'h0000_0013);

    // simultaneous IF and LS load: LS first, then IF
    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 32'h0000_0200;
    bus.i_ls_req   = 1'b1;
    bus.i_ls_we    = 1'b0;
    bus.i_ls_be    = 4'hF;
    bus.i_ls_addr  = 32'h0000_0300;
    bus.i_ls_wdata = 32'd0;
    gnt_q.push_back(mk_gnt(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'd0));
    rsp_q.push_back(mk_rsp(1'b1, 32'hCAFE_0001, 1'b0));
    gnt_q.push_back(mk_gnt(1'b0, 1'b0, 4'hF, 32'h0000_0200, 32'd0));
    rsp_q.push_back(mk_rsp(1'b0, 32'h0000_0297, 1'b0));
    txn(0, 0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
    txn(1, 2, 1'b1, 32'h0000_0297, 1'b0, 1'b0);

    // starvation: 4 LS wins, then IF; then again to show the counter cleared
    for (int round = 0; round < 2; round++) begin
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = 32'h0000_0204 + 32'(round * 4);
      bus.i_ls_req  = 1'b1;
      bus.i_ls_addr = 32'h0000_0400;
      for (int k = 0; k < STARVE_MAX; k++) begin
        gnt_q.push_back(mk_gnt(1'b1, 1'b0, 4'hF, 32'h0000_0400, 32'd0));
        rsp_q.push_back(mk_rsp(1'b1, 32'h0000_0040 + 32'(k), 1'b0));
      end
      gnt_q.push_back(mk_gnt(1'b0, 1'b0, 4'hF, 32'h0000_0204 + 32'(round * 4), 32'd0));
      rsp_q.push_back(mk_rsp(1'b0, 32'h0000_0077, 1'b0));
      for (int k = 0; k < STARVE_MAX; k++) begin
        txn(0, 0, 1'b1, 32'h0000_0040 + 32'(k), 1'b0, 1'b1);
      end
      txn(0, 0, 1'b1, 32'h0000_0077, 1'b0, 1'b1);
    end
    bus.i_ls_req = 1'b0;

    // store with byte enables, memory error reported
    bus.i_ls_req   = 1'b1;
    bus.i_ls_we    = 1'b1;
    bus.i_ls_be    = 4'b0011;
    bus.i_ls_addr  = 32'h0000_0500;
    bus.i_ls_wdata = 32'hDEAD_BEEF;
    gnt_q.push_back(mk_gnt(1'b1, 1'b1, 4'b0011, 32'h0000_0500, 32'hDEAD_BEEF));
    rsp_q.push_back(mk_rsp(1'b1, 32'h0000_0055, 1'b1));
    txn(2, 1, 1'b1, 32'h0000_0055, 1'b1, 1'b0);
    bus.i_ls_we    = 1'b0;
    bus.i_ls_be    = 4'hF;
    bus.i_ls_wdata = 32'd0;

    // timeout: ack, then no response; error arrives at ack+9
    bus.i_ls_req  = 1'b1;
    bus.i_ls_addr = 32'h0000_0600;
    gnt_q.push_back(mk_gnt(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'd0));
    rsp_q.push_back(mk_rsp(1'b1, 32'd0, 1'b1));
    tick();                                    // grant cycle = ack cycle a
    check("t_gnt", {31'd0, bus.o_ls_gnt}, 32'd1);
    bus.i_ls_req  = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();                                    // a+1
    bus.i_mem_ack = 1'b0;
    repeat (TIMEOUT - 1) tick();               // a+8
    check("t_not_early", {31'd0, bus.o_ls_rvalid}, 32'd0);
    tick();                                    // a+9
    check("t_rvalid_a9", {31'd0, bus.o_ls_rvalid}, 32'd1);
    tick();                                    // IDLE
    bus.i_mem_rvalid = 1'b1;                   // late response must be ignored
    bus.i_mem_rdata  = 32'h0000_0BAD;
    tick();
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'd0;
    tick();
    check("t_late_rvalid", {31'd0, bus.o_ls_rvalid}, 32'd0);
    check("t_late_rdata", bus.o_ls_rdata, 32'd0);
    check("t_late_busy", {31'd0, bus.o_busy}, 32'd0);

    // reset while waiting for the memory
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0700;
    gnt_q.push_back(mk_gnt(1'b0, 1'b0, 4'hF, 32'h0000_0700, 32'd0));
    tick();
    bus.i_if_req  = 1'b0;
    bus.i_mem_ack = 1'b1;
    tick();                                    // WAIT
    bus.i_mem_ack = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("r_busy", {31'd0, bus.o_busy}, 32'd0);
    check("r_mem_addr", bus.o_mem_addr, 32'd0);
    check("r_ls_err", {31'd0, bus.o_ls_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h0000_1234;
    tick();
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 32'd0;
    tick();
    check("r_no_rvalid", {31'd0, bus.o_if_rvalid}, 32'd0);
    check("r_if_rdata", bus.o_if_rdata, 32'd0);
    check("r_idle_busy", {31'd0, bus.o_busy}, 32'd0);

    // fresh request after reset
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0800;
    gnt_q.push_back(mk_gnt(1'b0, 1'b0, 4'hF, 32'h0000_0800, 32'd0));
    rsp_q.push_back(mk_rsp(1'b0, 32'h0010_0093, 1'b0));
    txn(0, 0, 1'b1, 32'h0010_0093, 1'b0, 1'b0);

    tick();
    // the grant pushed before the mid-WAIT reset was consumed; nothing else remains
    check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified memory port between instruction fetch (IF, read-only) and the load/store unit (LS, read/write) of the RV32I_Zicsr pipeline. Allows one outstanding transaction at a time. Uses fixed LS priority with a fetch anti-starvation counter. Each transaction has a response timeout that returns an error to the owning requester.

Parameters:
XLEN, 32, data/address width (matches `XLEN)
STARVE_MAX, 4, consecutive LS wins over a pending IF before IF is forced to win
TIMEOUT, 255, max WAIT cycles without i_mem_rvalid before an error response (>=2)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_if_req  input  1  fetch request; held until o_if_gnt
i_if_addr  input  XLEN  fetch address
o_if_gnt  output  1  1-cycle pulse: fetch request accepted
o_if_rvalid  output  1  1-cycle pulse: fetch response valid
o_if_rdata  output  XLEN  fetch read data
o_if_err  output  1  fetch error, valid with o_if_rvalid
i_ls_req  input  1  LS request; held until o_ls_gnt
i_ls_we  input  1  1=store, 0=load
i_ls_be  input  4  byte enables
i_ls_addr  input  XLEN  LS address
i_ls_wdata  input  XLEN  store data
o_ls_gnt  output  1  1-cycle pulse: LS request accepted
o_ls_rvalid  output  1  1-cycle pulse: LS response valid (loads and stores)
o_ls_rdata  output  XLEN  load data
o_ls_err  output  1  LS error, valid with o_ls_rvalid
o_mem_req  output  1  memory request, held until i_mem_ack
o_mem_we  output  1  memory write
o_mem_be  output  4  memory byte enables (4'hF for fetch)
o_mem_addr  output  XLEN  memory address
o_mem_wdata  output  XLEN  memory write data (0 for fetch)
i_mem_ack  input  1  memory accepts o_mem_req this cycle
i_mem_rvalid  input  1  memory response valid (never in the same cycle as ack)
i_mem_rdata  input  XLEN  memory read data
i_mem_err  input  1  memory error, qualified by i_mem_rvalid
o_busy  output  1  1 in any state other than IDLE

Behaviour:
- All outputs are registered. On reset (asynchronous, any state): state=IDLE, all outputs 0, owner=IF, starve and timeout counters 0. An in-flight transaction is abandoned; any later i_mem_rvalid is ignored in IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, with requests present: winner = LS if i_ls_req, except when i_if_req is also set and starve==STARVE_MAX, in which case IF wins.
  - Latch the winner's fields into o_mem_* and set owner.
  - Next cycle: REQ, o_mem_req=1, winner's gnt=1 for exactly that cycle.
  - starve: increments when LS wins while i_if_req=1; clears to 0 whenever IF wins; otherwise holds.
- IDLE, no request: stay in IDLE with outputs idle.
- REQ: hold o_mem_req and the latched fields stable until i_mem_ack. On ack: next cycle WAIT, o_mem_req=0, timeout counter=0. Requests are ignored in REQ/WAIT/RESP.
- WAIT:
  - On i_mem_rvalid: capture rdata/err into owner's outputs; next cycle RESP with owner's rvalid=1.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no rvalid: next cycle RESP with owner's rvalid=1, err=1, rdata=0.
- RESP: one cycle; next cycle IDLE, rvalid=0. rdata/err hold until the next response.
- Latency: request seen at cycle 0 -> gnt/o_mem_req at cycle 1. Ack at cycle a -> WAIT at a+1. rvalid at cycle r -> o_x_rvalid at r+1 -> IDLE at r+2, where the next arbitration can happen (next gnt at r+3).
- A store response returns o_ls_rdata = i_mem_rdata unmodified; the requester ignores it.
- The non-owner's rvalid/gnt never assert.

Test Plan:
- Single fetch: i_if_req, addr 0x100 at c0; ack at c1; rvalid rdata 0x00000013 at c3 -> o_if_gnt c1, o_mem_req c1 only, o_if_rvalid c4 with rdata 0x13, err 0; o_busy c1-c4.
- Simultaneous IF and LS load from idle -> LS granted first (o_mem_addr = LS addr, we=0), IF granted on the following arbitration; starve=1 after the first grant.
- Starvation: IF held high, LS re-requesting continuously -> 4 LS grants, then IF granted on the 5th arbitration; starve returns to 0.
- Store be=4'b0011, wdata 0xDEADBEEF -> o_mem_we=1, be=0x3, wdata matches; o_ls_rvalid pulses after the memory response; i_mem_err=1 gives o_ls_err=1.
- Timeout with TIMEOUT=8: ack, then no rvalid -> owner rvalid with err=1, rdata=0 at ack+9 (8 WAIT cycles + 1). A late rvalid afterwards produces no pulse.
- Reset asserted in WAIT -> outputs 0 immediately; after release, a subsequent i_mem_rvalid gives no response pulse, and a fresh request is granted normally.
